// File: rtl/upc_pkg.sv
// upc_pkg: checkout FSM state type and default discount/expensive code tables
package upc_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, ALARM} state_t;
    localparam logic [7:0] DEF_DISC_TABLE = 8'hEC;
    localparam logic [7:0] DEF_EXP_TABLE  = 8'hB1;
endpackage

// File: rtl/upc_checkout_scan_edge.sv
// scan_edge: two-flop synchroniser followed by a one-cycle rising-edge pulse
module scan_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);
    logic [2:0] sh;
    always_ff @(posedge clk or posedge reset)
        if (reset) sh <= '0;
        else       sh <= {sh[1:0], d};
    assign pulse = sh[1] & ~sh[2];
endmodule

// File: rtl/upc_checkout.sv
// upc_checkout: scan checkout with discount/theft flags, saturating counters, sticky alarm.
// Define UPC_SCAN_SYNC_EN to synchronise scan_valid and accept only its rising edge.
module upc_checkout
    import upc_pkg::*;
#(
    parameter int                    UPC_W      = 3,
    parameter int                    CNT_W      = 8,
    parameter logic [2**UPC_W-1:0]   DISC_TABLE = DEF_DISC_TABLE,
    parameter logic [2**UPC_W-1:0]   EXP_TABLE  = DEF_EXP_TABLE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [UPC_W-1:0] upc,
    input  logic             mark,
    input  logic             scan_valid,
    input  logic             clear,
    output logic             ready,
    output logic             discounted,
    output logic             stolen,
    output logic             alarm,
    output logic [CNT_W-1:0] item_count,
    output logic [CNT_W-1:0] disc_count
);
    state_t state, state_nxt;
    logic   strobe, accept, is_disc, is_stolen;
`ifdef UPC_SCAN_SYNC_EN
    scan_edge u_scan_edge (
        .clk   (clk),
        .reset (reset),
        .d     (scan_valid),
        .pulse (strobe)
    );
`else
    assign strobe = scan_valid;
`endif
    assign ready     = state == IDLE;
    assign accept    = ready & strobe & ~clear;
    assign is_disc   = DISC_TABLE[upc];
    assign is_stolen = EXP_TABLE[upc] & ~mark;
    always_comb begin
        state_nxt = state;
        state_nxt = clear         ? IDLE :
                    accept        ? (is_stolen ? ALARM : BUSY) :
                    state == BUSY ? IDLE : state;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    // counters hold at all-ones instead of wrapping
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            discounted <= 1'b0;
            stolen     <= 1'b0;
            alarm      <= 1'b0;
            item_count <= '0;
            disc_count <= '0;
        end else if (clear) begin
            discounted <= 1'b0;
            stolen     <= 1'b0;
            alarm      <= 1'b0;
            item_count <= '0;
            disc_count <= '0;
        end else if (accept) begin
            discounted <= is_disc;
            stolen     <= is_stolen;
            alarm      <= is_stolen;
            item_count <= item_count + CNT_W'(item_count != '1);
            disc_count <= disc_count + CNT_W'(is_disc && disc_count != '1);
        end
endmodule
